// File: rtl/wb_pkg.sv
// Shared definitions for the register-file writeback unit.
//   XLEN, REG_AW   : data width and register address width
//   wb_entry_t     : one queued register write {rd, data}
//   wb_free_slots  : slots the queue can absorb at the coming edge
package wb_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  // Empty slots plus the slot released by the head, which always pops when
  // the queue is non-empty. Never less than 1.
  function automatic int unsigned wb_free_slots(input int unsigned depth,
                                                input int unsigned count);
    return depth - count + ((count != 0) ? 32'd1 : 32'd0);
  endfunction

endpackage

// File: rtl/reg_writeback_unit_if.sv
// Signal bundle of the writeback unit.
//   ALU_* / MEM_*    : two result sources (valid/ready offers)
//   RF_*             : registered register-file write port
//   PEND_*           : pending-write lookup for decode
//   COUNT            : queue occupancy
// Modports: master = sources/decode/register-file side, slave = the unit.
//
// Handshake: an offer transfers at a posedge where VALID and READY are both
// high. READY depends combinationally on the offers and on RESET; a source
// whose offer is not taken keeps it valid and unchanged until it is.
interface reg_writeback_unit_if #(parameter int unsigned DEPTH = 4);
  import wb_pkg::*;

  logic                           ALU_VALID;
  logic [REG_AW-1:0]              ALU_RD;
  logic [XLEN-1:0]                ALU_DATA;
  logic                           ALU_READY;
  logic                           MEM_VALID;
  logic [REG_AW-1:0]              MEM_RD;
  logic [XLEN-1:0]                MEM_DATA;
  logic                           MEM_READY;
  logic                           RF_WRITE;
  logic [REG_AW-1:0]              RF_ADDR;
  logic [XLEN-1:0]                RF_DATA;
  logic [REG_AW-1:0]              PEND_Q;
  logic                           PEND_HIT;
  logic [XLEN-1:0]                PEND_DATA;
  logic [$clog2(DEPTH+1)-1:0]     COUNT;

  modport master (
    output ALU_VALID, ALU_RD, ALU_DATA, MEM_VALID, MEM_RD, MEM_DATA, PEND_Q,
    input  ALU_READY, MEM_READY, RF_WRITE, RF_ADDR, RF_DATA, PEND_HIT,
           PEND_DATA, COUNT
  );

  modport slave (
    input  ALU_VALID, ALU_RD, ALU_DATA, MEM_VALID, MEM_RD, MEM_DATA, PEND_Q,
    output ALU_READY, MEM_READY, RF_WRITE, RF_ADDR, RF_DATA, PEND_HIT,
           PEND_DATA, COUNT
  );

endinterface

// File: rtl/wb_fifo.sv
// Dual-enqueue, single-dequeue circular queue of wb_entry_t.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   push0_i / ent0_i    : first (older) entry written this edge
//   push1_i / ent1_i    : second (younger) entry; only honoured with push0_i
//   pop_i               : drop the head this edge
//   head_o, count_o     : head entry and occupancy
//   ent_o, vld_o        : all storage slots and their valid bits
//   rd_ptr_o            : slot index of the oldest entry
// The caller guarantees pushes never exceed the free slots.
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push0_i,
  input  wb_entry_t       ent0_i,
  input  logic            push1_i,
  input  wb_entry_t       ent1_i,
  input  logic            pop_i,
  output wb_entry_t       head_o,
  output logic [CW-1:0]   count_o,
  output logic [PW-1:0]   rd_ptr_o,
  output wb_entry_t       ent_o [DEPTH],
  output logic [DEPTH-1:0] vld_o
);

  wb_entry_t        mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_p1;
  logic [CW-1:0]    count_q, count_d;
  logic             push_two;

  assign wr_ptr_p1 = wr_ptr_q + PW'(1);
  assign push_two  = push0_i && push1_i;

  // Pop clears before push sets: when full, the slot being popped is the
  // one being refilled in the same edge.
  always_comb begin
    vld_d    = vld_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (pop_i) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PW'(1);
    end
    if (push0_i) begin
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_p1;
    end
    if (push_two) begin
      vld_d[wr_ptr_p1] = 1'b1;
      wr_ptr_d         = wr_ptr_q + PW'(2);
    end
    count_d = count_q - CW'(pop_i) + CW'(push0_i) + CW'(push_two);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      vld_q    <= vld_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; the valid bits qualify it.
  always_ff @(posedge clk_i) begin
    if (push0_i)  mem_q[wr_ptr_q]  <= ent0_i;
    if (push_two) mem_q[wr_ptr_p1] <= ent1_i;
  end

  assign head_o   = mem_q[rd_ptr_q];
  assign count_o  = count_q;
  assign rd_ptr_o = rd_ptr_q;
  assign ent_o    = mem_q;
  assign vld_o    = vld_q;

endmodule

// File: rtl/reg_writeback_unit.sv
// Write-side master for the 32x32 register file. Merges ALU and load-return
// results into an in-order queue and issues one register write per cycle.
//   CLK, RESET : clock, synchronous active-high reset
//   bus        : reg_writeback_unit_if.slave (sources, RF port, lookup, COUNT)
// Build option: WB_PEND_LOOKUP_EN enables the pending-write lookup; without
// it PEND_HIT and PEND_DATA are 0 and PEND_Q is ignored.
module reg_writeback_unit
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  reg_writeback_unit_if.slave   bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic              mem_take, alu_take, alu_ready, pop;
  logic              push0, push1;
  wb_entry_t         mem_ent, alu_ent, push0_ent, head;
  logic [CW-1:0]     count;
  logic [PW-1:0]     fifo_rd_ptr;
  wb_entry_t         fifo_ent [DEPTH];
  logic [DEPTH-1:0]  fifo_vld;

  logic              rf_write_q, rf_write_d;
  logic [REG_AW-1:0] rf_addr_q, rf_addr_d;
  logic [XLEN-1:0]   rf_data_q, rf_data_d;

  assign mem_ent = '{rd: bus.MEM_RD, data: bus.MEM_DATA};
  assign alu_ent = '{rd: bus.ALU_RD, data: bus.ALU_DATA};

  // MEM is always taken. ALU is taken unless the MEM entry would use the last
  // free slot; an rd==0 offer is accepted but never occupies a slot.
  assign alu_ready = !RESET &&
                     ((wb_free_slots(DEPTH, 32'(count)) >= 32'd2) ||
                      !bus.MEM_VALID || (bus.MEM_RD == '0));
  assign mem_take  = !RESET && bus.MEM_VALID && (bus.MEM_RD != '0);
  assign alu_take  = alu_ready && bus.ALU_VALID && (bus.ALU_RD != '0);

  // MEM is ordered ahead of ALU when both enqueue in the same cycle.
  assign push0     = mem_take || alu_take;
  assign push1     = mem_take && alu_take;
  assign push0_ent = mem_take ? mem_ent : alu_ent;
  assign pop       = (count != '0);

  assign bus.MEM_READY = !RESET;
  assign bus.ALU_READY = alu_ready;
  assign bus.COUNT     = count;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i    (CLK),
    .rst_i    (RESET),
    .push0_i  (push0),
    .ent0_i   (push0_ent),
    .push1_i  (push1),
    .ent1_i   (alu_ent),
    .pop_i    (pop),
    .head_o   (head),
    .count_o  (count),
    .rd_ptr_o (fifo_rd_ptr),
    .ent_o    (fifo_ent),
    .vld_o    (fifo_vld)
  );

  // The register file never back-pressures, so the head pops every cycle
  // the queue is non-empty. Address/data hold when idle.
  always_comb begin
    rf_write_d = pop;
    rf_addr_d  = rf_addr_q;
    rf_data_d  = rf_data_q;
    if (pop) begin
      rf_addr_d = head.rd;
      rf_data_d = head.data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rf_write_q <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
    end else begin
      rf_write_q <= rf_write_d;
      rf_addr_q  <= rf_addr_d;
      rf_data_q  <= rf_data_d;
    end
  end

  assign bus.RF_WRITE = rf_write_q;
  assign bus.RF_ADDR  = rf_addr_q;
  assign bus.RF_DATA  = rf_data_q;

`ifdef WB_PEND_LOOKUP_EN
  logic            pend_hit;
  logic [XLEN-1:0] pend_data;
  logic [PW-1:0]   look_idx;

  // Scan oldest to youngest (RF output register first, then the queue from
  // the head) so the last match is the youngest value.
  always_comb begin
    pend_hit  = 1'b0;
    pend_data = '0;
    look_idx  = '0;
    if (bus.PEND_Q != '0) begin
      if (rf_write_q && (rf_addr_q == bus.PEND_Q)) begin
        pend_hit  = 1'b1;
        pend_data = rf_data_q;
      end
      for (int k = 0; k < int'(DEPTH); k++) begin
        look_idx = fifo_rd_ptr + PW'(k);
        if (fifo_vld[look_idx] && (fifo_ent[look_idx].rd == bus.PEND_Q)) begin
          pend_hit  = 1'b1;
          pend_data = fifo_ent[look_idx].data;
        end
      end
    end
  end

  assign bus.PEND_HIT  = pend_hit;
  assign bus.PEND_DATA = pend_data;
`else
  logic unused_lookup;

  always_comb begin
    unused_lookup = (^bus.PEND_Q) ^ (^fifo_rd_ptr) ^ (^fifo_vld);
    for (int k = 0; k < int'(DEPTH); k++) begin
      unused_lookup = unused_lookup ^ (^fifo_ent[k]);
    end
  end

  assign bus.PEND_HIT  = 1'b0;
  assign bus.PEND_DATA = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Self-checking bench for reg_writeback_unit (DEPTH=4). A queue-level model
// tracks the writes owed to the register file; a scoreboard compares the RF
// port and COUNT every cycle, and each scenario task checks its own points.
module tb_reg_writeback_unit;
  import wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int W     = REG_AW + XLEN;
`ifdef WB_PEND_LOOKUP_EN
  localparam bit LOOK = 1'b1;
`else
  localparam bit LOOK = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  reg_writeback_unit_if #(.DEPTH(DEPTH)) bus ();

  reg_writeback_unit #(.DEPTH(DEPTH)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  logic [W-1:0]      exp_q [$];     // writes still owed, oldest first
  logic              m_wr   = 1'b0; // expected RF port
  logic [REG_AW-1:0] m_addr = '0;
  logic [XLEN-1:0]   m_data = '0;
  logic [W-1:0]      m_tmp;
  logic              m_alu_ok;

  // ALU may enter unless a real MEM entry takes the only slot that will be
  // open at the edge (empty slots plus the one the draining head frees).
  function automatic logic exp_alu_rdy();
    int room;
    room = DEPTH - exp_q.size() + ((exp_q.size() > 0) ? 1 : 0);
    return !RESET && (room >= 2 || !bus.MEM_VALID || bus.MEM_RD == 0);
  endfunction

  function automatic void exp_pend(input logic [REG_AW-1:0] q,
                                   output logic hit, output logic [XLEN-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (LOOK && q != 0) begin
      if (m_wr && m_addr == q) begin hit = 1'b1; d = m_data; end
      foreach (exp_q[i])
        if (exp_q[i][W-1:XLEN] == q) begin hit = 1'b1; d = exp_q[i][XLEN-1:0]; end
    end
  endfunction

  always @(posedge CLK) begin
    if (RESET) begin
      exp_q.delete();
      m_wr = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      m_alu_ok = exp_alu_rdy();
      if (exp_q.size() > 0) begin
        m_tmp  = exp_q.pop_front();
        m_wr   = 1'b1;
        m_addr = m_tmp[W-1:XLEN];
        m_data = m_tmp[XLEN-1:0];
      end else begin
        m_wr = 1'b0;
      end
      if (bus.MEM_VALID && bus.MEM_RD != 0) exp_q.push_back({bus.MEM_RD, bus.MEM_DATA});
      if (bus.ALU_VALID && m_alu_ok && bus.ALU_RD != 0) exp_q.push_back({bus.ALU_RD, bus.ALU_DATA});
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge CLK) begin
    n_checks += 4;
    if (bus.RF_WRITE !== m_wr) begin
      n_fail++; $display("FAIL sb_rf_write t=%0t: got %0b expected %0b", $time, bus.RF_WRITE, m_wr);
    end
    if (bus.RF_ADDR !== m_addr) begin
      n_fail++; $display("FAIL sb_rf_addr t=%0t: got %0d expected %0d", $time, bus.RF_ADDR, m_addr);
    end
    if (bus.RF_DATA !== m_data) begin
      n_fail++; $display("FAIL sb_rf_data t=%0t: got %0h expected %0h", $time, bus.RF_DATA, m_data);
    end
    if (bus.COUNT !== 3'(exp_q.size())) begin
      n_fail++; $display("FAIL sb_count t=%0t: got %0d expected %0d", $time, bus.COUNT, exp_q.size());
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic mv, input logic [REG_AW-1:0] mrd, input logic [XLEN-1:0] md,
                       input logic av, input logic [REG_AW-1:0] ard, input logic [XLEN-1:0] ad);
    bus.MEM_VALID = mv; bus.MEM_RD = mrd; bus.MEM_DATA = md;
    bus.ALU_VALID = av; bus.ALU_RD = ard; bus.ALU_DATA = ad;
  endtask

  task automatic drain();
    int cyc = 0;
    drive(0, 0, 0, 0, 0, 0);
    while ((exp_q.size() != 0 || m_wr) && cyc < 50) begin
      @(negedge CLK); cyc++;
    end
    n_checks++;
    if (exp_q.size() != 0 || m_wr) begin
      n_fail++; $display("FAIL drain_timeout: got %0d cycles expected below 50", cyc);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RESET = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      drive(0, 0, 0, 1, 5'd3, 32'h33);
      #1;
      n_checks += 4;
      if (bus.ALU_READY !== 1'b0) begin n_fail++; $display("FAIL rst_alu_ready: got %0b expected 0", bus.ALU_READY); end
      if (bus.MEM_READY !== 1'b0) begin n_fail++; $display("FAIL rst_mem_ready: got %0b expected 0", bus.MEM_READY); end
      if (bus.RF_WRITE  !== 1'b0) begin n_fail++; $display("FAIL rst_rf_write: got %0b expected 0", bus.RF_WRITE); end
      if (bus.COUNT     !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", bus.COUNT); end
    end
    @(negedge CLK);
    RESET = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); #1;
      n_checks++;
      if (bus.RF_WRITE !== 1'b0) begin n_fail++; $display("FAIL rst_after_write: got %0b expected 0", bus.RF_WRITE); end
    end
  endtask

  task automatic test_single();
    @(negedge CLK);
    drive(0, 0, 0, 1, 5'd5, 32'h5F);
    #1;
    n_checks++;
    if (bus.ALU_READY !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %0b expected 1", bus.ALU_READY); end
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    n_checks += 2;
    if (bus.COUNT !== 3'd1)    begin n_fail++; $display("FAIL single_count: got %0d expected 1", bus.COUNT); end
    if (bus.RF_WRITE !== 1'b0) begin n_fail++; $display("FAIL single_early: got %0b expected 0", bus.RF_WRITE); end
    @(negedge CLK); #1;
    n_checks += 3;
    if (bus.RF_WRITE !== 1'b1)   begin n_fail++; $display("FAIL single_write: got %0b expected 1", bus.RF_WRITE); end
    if (bus.RF_ADDR !== 5'd5)    begin n_fail++; $display("FAIL single_addr: got %0d expected 5", bus.RF_ADDR); end
    if (bus.RF_DATA !== 32'h5F)  begin n_fail++; $display("FAIL single_data: got %0h expected 5f", bus.RF_DATA); end
    @(negedge CLK); #1;
    n_checks++;
    if (bus.RF_WRITE !== 1'b0) begin n_fail++; $display("FAIL single_once: got %0b expected 0", bus.RF_WRITE); end
  endtask

  task automatic test_simultaneous();
    @(negedge CLK);
    drive(1, 5'd1, 32'h1C, 1, 5'd2, 32'h6C);
    #1;
    n_checks += 2;
    if (bus.MEM_READY !== 1'b1) begin n_fail++; $display("FAIL simul_mem_ready: got %0b expected 1", bus.MEM_READY); end
    if (bus.ALU_READY !== 1'b1) begin n_fail++; $display("FAIL simul_alu_ready: got %0b expected 1", bus.ALU_READY); end
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    n_checks++;
    if (bus.COUNT !== 3'd2) begin n_fail++; $display("FAIL simul_peak: got %0d expected 2", bus.COUNT); end
    @(negedge CLK); #1;
    n_checks += 2;
    if (bus.RF_WRITE !== 1'b1 || bus.RF_ADDR !== 5'd1) begin
      n_fail++; $display("FAIL simul_first: got we=%0b rd=%0d expected we=1 rd=1", bus.RF_WRITE, bus.RF_ADDR);
    end
    if (bus.RF_DATA !== 32'h1C) begin n_fail++; $display("FAIL simul_first_data: got %0h expected 1c", bus.RF_DATA); end
    @(negedge CLK); #1;
    n_checks += 2;
    if (bus.RF_WRITE !== 1'b1 || bus.RF_ADDR !== 5'd2) begin
      n_fail++; $display("FAIL simul_second: got we=%0b rd=%0d expected we=1 rd=2", bus.RF_WRITE, bus.RF_ADDR);
    end
    if (bus.RF_DATA !== 32'h6C) begin n_fail++; $display("FAIL simul_second_data: got %0h expected 6c", bus.RF_DATA); end
  endtask

  task automatic test_fill();
    int nxt = 1, cyc = 0, max_cnt = 0;
    logic saw_block = 1'b0, av, exp_r;
    while (nxt <= 12 && cyc < 40) begin
      @(negedge CLK);
      av = (nxt + 1 <= 12);
      drive(1, 5'(nxt), $urandom, av, 5'(nxt + 1), $urandom);
      #1;
      if (int'(bus.COUNT) > max_cnt) max_cnt = int'(bus.COUNT);
      exp_r = exp_alu_rdy();
      n_checks++;
      if (bus.ALU_READY !== exp_r) begin n_fail++; $display("FAIL fill_alu_ready: got %0b expected %0b", bus.ALU_READY, exp_r); end
      if (!bus.ALU_READY) saw_block = 1'b1;
      nxt += 1 + ((av && bus.ALU_READY) ? 1 : 0);
      cyc++;
    end
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    if (int'(bus.COUNT) > max_cnt) max_cnt = int'(bus.COUNT);
    n_checks += 2;
    if (max_cnt != DEPTH)  begin n_fail++; $display("FAIL fill_max_count: got %0d expected %0d", max_cnt, DEPTH); end
    if (saw_block !== 1'b1) begin n_fail++; $display("FAIL fill_alu_block: got %0b expected 1", saw_block); end
    drain();
  endtask

  task automatic test_rd0();
    @(negedge CLK);
    drive(0, 0, 0, 1, 5'd0, 32'hFFFF);
    #1;
    n_checks++;
    if (bus.ALU_READY !== 1'b1) begin n_fail++; $display("FAIL rd0_ready: got %0b expected 1", bus.ALU_READY); end
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks += 2;
      if (bus.COUNT !== 3'd0)    begin n_fail++; $display("FAIL rd0_count: got %0d expected 0", bus.COUNT); end
      if (bus.RF_WRITE !== 1'b0) begin n_fail++; $display("FAIL rd0_write: got %0b expected 0", bus.RF_WRITE); end
      @(negedge CLK);
    end
  endtask

  task automatic test_lookup();
    logic exp_hit;
    logic [XLEN-1:0] exp_d;
    bus.PEND_Q = 5'd4;
    @(negedge CLK);
    drive(0, 0, 0, 1, 5'd4, 32'h6);
    @(negedge CLK);
    drive(0, 0, 0, 1, 5'd4, 32'hF);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      drive(0, 0, 0, 0, 0, 0);
      #1;
      exp_hit = LOOK;
      exp_d   = LOOK ? 32'hF : 32'h0;
      n_checks += 2;
      if (bus.PEND_HIT !== exp_hit) begin n_fail++; $display("FAIL look_hit: got %0b expected %0b", bus.PEND_HIT, exp_hit); end
      if (bus.PEND_DATA !== exp_d)  begin n_fail++; $display("FAIL look_data: got %0h expected %0h", bus.PEND_DATA, exp_d); end
    end
    @(negedge CLK); #1;
    n_checks += 2;
    if (bus.PEND_HIT !== 1'b0)   begin n_fail++; $display("FAIL look_drained_hit: got %0b expected 0", bus.PEND_HIT); end
    if (bus.PEND_DATA !== 32'h0) begin n_fail++; $display("FAIL look_drained_data: got %0h expected 0", bus.PEND_DATA); end
    bus.PEND_Q = 5'd0;
  endtask

  task automatic test_random();
    logic exp_hit, exp_r;
    logic [XLEN-1:0] exp_d;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      bus.PEND_Q = 5'($urandom_range(0, 7));
      #1;
      exp_r = exp_alu_rdy();
      exp_pend(bus.PEND_Q, exp_hit, exp_d);
      n_checks += 4;
      if (bus.ALU_READY !== exp_r) begin n_fail++; $display("FAIL rand_alu_ready: got %0b expected %0b", bus.ALU_READY, exp_r); end
      if (bus.MEM_READY !== 1'b1)  begin n_fail++; $display("FAIL rand_mem_ready: got %0b expected 1", bus.MEM_READY); end
      if (bus.PEND_HIT !== exp_hit) begin n_fail++; $display("FAIL rand_pend_hit q=%0d: got %0b expected %0b", bus.PEND_Q, bus.PEND_HIT, exp_hit); end
      if (bus.PEND_DATA !== exp_d)  begin n_fail++; $display("FAIL rand_pend_data q=%0d: got %0h expected %0h", bus.PEND_Q, bus.PEND_DATA, exp_d); end
    end
    bus.PEND_Q = 5'd0;
    drain();
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    drive(1, 5'd8, 32'hA1, 1, 5'd9, 32'hA2);
    @(negedge CLK);
    drive(1, 5'd10, 32'hA3, 1, 5'd11, 32'hA4);
    @(negedge CLK);
    drive(0, 0, 0, 1, 5'd12, 32'hA5);
    RESET = 1'b1;
    #1;
    n_checks += 2;
    if (bus.COUNT !== 3'd3)     begin n_fail++; $display("FAIL mid_pre_count: got %0d expected 3", bus.COUNT); end
    if (bus.ALU_READY !== 1'b0) begin n_fail++; $display("FAIL mid_alu_ready: got %0b expected 0", bus.ALU_READY); end
    @(negedge CLK);
    RESET = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks += 2;
      if (bus.COUNT !== 3'd0)    begin n_fail++; $display("FAIL mid_count: got %0d expected 0", bus.COUNT); end
      if (bus.RF_WRITE !== 1'b0) begin n_fail++; $display("FAIL mid_write: got %0b expected 0", bus.RF_WRITE); end
      @(negedge CLK);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    drive(0, 0, 0, 0, 0, 0);
    bus.PEND_Q = 5'd0;
    test_reset();
    test_single();
    test_simultaneous();
    drain();
    test_fill();
    test_rd0();
    test_lookup();
    drain();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/reg_writeback_unit.md
Name: reg_writeback_unit

Overview:
- Write-side master for the 32x32 register file.
- Collects completed results from two writeback sources: the ALU path and the memory/load-return path, which can arrive late after a data-cache miss.
- Buffers results in a small in-order queue and drives exactly one register-file write per cycle.
- Exposes a pending-write lookup so decode can detect values that are not yet written.

Parameters:
- XLEN, 32, data width.
- REG_AW, 5, register address width.
- DEPTH, 4, queue entries (power of two, >=2).

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RESET  input  1  reset, synchronous, active-high.
- ALU_VALID  input  1  ALU result offered this cycle.
- ALU_RD  input  REG_AW  ALU destination register.
- ALU_DATA  input  XLEN  ALU result.
- ALU_READY  output  1  ALU offer accepted at the coming edge.
- MEM_VALID  input  1  load result offered this cycle.
- MEM_RD  input  REG_AW  load destination register.
- MEM_DATA  input  XLEN  load data.
- MEM_READY  output  1  load offer accepted at the coming edge.
- RF_WRITE  output  1  register-file write enable (registered).
- RF_ADDR  output  REG_AW  register-file write address (registered).
- RF_DATA  output  XLEN  register-file write data (registered).
- PEND_Q  input  REG_AW  lookup address from decode.
- PEND_HIT  output  1  write to PEND_Q still pending.
- PEND_DATA  output  XLEN  youngest pending value for PEND_Q.
- COUNT  output  $clog2(DEPTH+1)  current queue occupancy.

Behaviour:
- Reset: RESET is synchronous, active-high; clock is CLK.
  - At a posedge with RESET=1: COUNT=0, pointers=0, RF_WRITE=0, RF_ADDR=0, RF_DATA=0.
  - While RESET=1: ALU_READY=0 and MEM_READY=0.
  - Reset mid-operation discards all queued entries; no further RF_WRITE occurs for them.
- Dequeue:
  - At each edge, if COUNT>0 before the edge, the head is popped into RF_WRITE=1/RF_ADDR/RF_DATA.
  - Otherwise RF_WRITE<=0; RF_ADDR and RF_DATA hold their values.
  - The register file always accepts a write, so there is no back-pressure on the RF side.
- Free slots: free = DEPTH - COUNT + (COUNT>0 ? 1 : 0), evaluated combinationally from the registered COUNT.
  - free is always >=1.
- Enqueue (at most two per edge):
  - MEM has priority over ALU, and the MEM entry is ordered before the ALU entry in the same cycle.
  - MEM_READY = !RESET.
  - ALU_READY = !RESET && (free>=2 || !MEM_VALID || MEM_RD==0).
- rd==0 handling:
  - An offer with rd==0 is accepted (READY=1) but discarded.
  - It does not enqueue, does not consume a slot, and never produces RF_WRITE.
- Latency: an entry accepted at edge N into an empty queue drives RF_WRITE during the cycle after edge N+1. The register file commits it at edge N+2.
- Ordering: strict FIFO. No entry is lost or duplicated.
- COUNT update: COUNT_next = COUNT - pop + pushes, where pushes is 0, 1 or 2. COUNT never exceeds DEPTH.
- Pointers wrap modulo DEPTH.
- Pending lookup (combinational):
  - Searches all valid queue entries plus the RF output register when RF_WRITE=1.
  - PEND_HIT=1 if any entry matches PEND_Q; PEND_DATA is taken from the youngest match.
  - PEND_Q==0 gives PEND_HIT=0.
  - No match gives PEND_DATA=0.
  - The lookup does not see offers being enqueued in the current cycle.

Optional Feature:
- Macro: WB_PEND_LOOKUP_EN.
- Defined: pending lookup behaves as described above.
- Undefined:
  - PEND_HIT is tied 0 and PEND_DATA is tied 0.
  - The search logic is removed; PEND_Q is ignored.
  - Decode must then stall on its own scoreboard.
  - All other behaviour is identical.

Decomposition:
- Shared package wb_pkg contains:
  - XLEN and REG_AW constants.
  - Typedef wb_entry_t {rd[REG_AW-1:0], data[XLEN-1:0]}.
  - A function computing free slots from COUNT.
- Sub-module wb_fifo: dual-enqueue, single-dequeue circular queue of wb_entry_t with per-entry valid bits. It exposes entry contents for the lookup.
- reg_writeback_unit instantiates wb_fifo and adds the arbitration, rd==0 filtering, RF output registers and lookup.

Test Plan:
- Reset: RESET=1 for 2 cycles with ALU_VALID=1, ALU_RD=3 -> ALU_READY=0, MEM_READY=0, RF_WRITE=0, COUNT=0; nothing is written afterwards.
- Single write: ALU rd=5, data=0x5F accepted at edge N -> RF_WRITE=1, RF_ADDR=5, RF_DATA=0x5F for exactly one cycle after edge N+1.
- Simultaneous: MEM rd=1/0x1C and ALU rd=2/0x6C in the same cycle -> both READY=1; RF writes rd1 then rd2 on consecutive cycles; COUNT peaks at 2.
- Fill (DEPTH=4): both sources valid every cycle with distinct rd 1..12 -> COUNT reaches 4, then ALU_READY=0 while MEM_VALID=1 (MEM still accepted); the RF write sequence equals the accepted order exactly, with no gaps while COUNT>0.
- rd==0: ALU rd=0, data=0xFFFF -> ALU_READY=1, COUNT unchanged, no RF_WRITE.
- Lookup and reset:
  - Enqueue rd=4/0x6 then rd=4/0xF, with PEND_Q=4 -> PEND_HIT=1, PEND_DATA=0xF; after both drain, PEND_HIT=0.
  - Assert RESET with 3 entries queued -> COUNT=0 and no further RF_WRITE.
